tohost_monitor: RTL and testbench

Hardware end of the riscv-tests pass/fail convention. The core's test program writes its verdict to the `tohost` word; this block snoops the core's data-memory write port, decodes that write into pass/fail/test-number, and stops the run. It also runs a cycle watchdog so a hung program still terminates. It sits in `top` beside `ram_main`, is observed by the regression bench, and drives the core's halt input.

---
 rtl/vesp_test_pkg.sv | 19 +
 rtl/tohost_monitor_if.sv | 22 ++
 rtl/tohost_monitor.sv | 92 +++++++++
 tb/tb_tohost_monitor.sv | 236 +++++++++++++++++++++++
 4 files changed

// File: rtl/vesp_test_pkg.sv
// Shared definitions for the riscv-tests pass/fail monitor: state encoding,
// default tohost location and the pass verdict code.
package vesp_test_pkg;

    // Run state of the monitor; everything other than RUN is terminal.
    typedef enum logic [1:0] {
        RUN     = 2'd0,
        PASS    = 2'd1,
        FAIL    = 2'd2,
        TIMEOUT = 2'd3
    } tohost_state_t;

    // Byte address of the tohost word (word-aligned).
    localparam logic [31:0] TOHOST_ADDR_DEFAULT = 32'h0000_1000;

    // Value the test program writes to tohost on success.
    localparam logic [31:0] TOHOST_PASS = 32'd1;

endpackage

// File: rtl/tohost_monitor_if.sv
// Core data-memory write port as seen by the tohost monitor. The core side
// drives it (master); the monitor only snoops it (slave).
interface tohost_monitor_if;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_wmask;

    modport master (
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_wmask
    );

    modport slave (
        input mem_we,
        input mem_addr,
        input mem_wdata,
        input mem_wmask
    );
endinterface

// File: rtl/tohost_monitor.sv
// Hardware end of the riscv-tests tohost convention: snoops the core's data
// write port, decodes the verdict written to tohost, halts the core, and runs
// a cycle watchdog so a hung program still ends the run.
module tohost_monitor
    import vesp_test_pkg::*;
#(
    parameter logic [31:0] TOHOST_ADDR    = TOHOST_ADDR_DEFAULT, // must be word-aligned
    parameter int unsigned TIMEOUT_CYCLES = 100000,              // 0 disables the watchdog
    parameter int          CNT_W          = 32                   // 2**CNT_W > TIMEOUT_CYCLES
) (
    input  logic                 sys_clk,
    input  logic                 sys_res,
    tohost_monitor_if.slave      bus,
    output logic                 done,
    output logic                 pass,
    output logic                 fail,
    output logic                 timeout,
    output logic [30:0]          fail_test,
    output logic [CNT_W-1:0]     cycles,
    output logic                 halt
);

    localparam bit               WDOG_EN  = (TIMEOUT_CYCLES != 0);
    // Counter value on the edge before expiry; the transition to TIMEOUT
    // happens on the same edge that takes cycles to TIMEOUT_CYCLES.
    localparam logic [CNT_W-1:0] WDOG_LAST = WDOG_EN ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [CNT_W-1:0] CNT_MAX   = '1;

    tohost_state_t    state_q, state_d;
    logic [CNT_W-1:0] cycles_q, cycles_d;
    logic [30:0]      fail_test_q, fail_test_d;
    logic             commit;

    // A commit is a full-word write of an odd value to tohost; even values
    // and partial writes are ignored by the convention.
    always_comb begin
        commit = bus.mem_we
              && (bus.mem_addr == TOHOST_ADDR)
              && (bus.mem_wmask == 4'b1111)
              && bus.mem_wdata[0];
    end

    // Next state: count while running, resolve verdict or watchdog expiry;
    // a commit on the expiry edge takes priority over the timeout.
    always_comb begin
        state_d     = state_q;
        cycles_d    = cycles_q;
        fail_test_d = fail_test_q;
        if (state_q == RUN) begin
            if (cycles_q != CNT_MAX) begin
                cycles_d = cycles_q + CNT_W'(1);
            end
            if (commit) begin
                if (bus.mem_wdata == TOHOST_PASS) begin
                    state_d = PASS;
                end else begin
                    state_d     = FAIL;
                    fail_test_d = bus.mem_wdata[31:1];
                end
            end else if (WDOG_EN && (cycles_q == WDOG_LAST)) begin
                state_d = TIMEOUT;
            end
        end
    end

    // State, counter and failing test number; reset clears all of them
    // without waiting for a clock edge.
    always_ff @(posedge sys_clk or posedge sys_res) begin
        if (sys_res) begin
            state_q     <= RUN;
            cycles_q    <= '0;
            fail_test_q <= '0;
        end else begin
            state_q     <= state_d;
            cycles_q    <= cycles_d;
            fail_test_q <= fail_test_d;
        end
    end

    // Outputs are decodes of registered state only; no input reaches them
    // combinationally.
    always_comb begin
        done      = (state_q != RUN);
        pass      = (state_q == PASS);
        fail      = (state_q == FAIL);
        timeout   = (state_q == TIMEOUT);
        halt      = (state_q != RUN);
        fail_test = fail_test_q;
        cycles    = cycles_q;
    end

endmodule

// File: tb/tb_tohost_monitor.sv
// Directed bench for tohost_monitor: three instances cover the default
// watchdog, a 20-cycle watchdog and a disabled watchdog.
module tb_tohost_monitor;
    logic clk = 1'b0;
    logic rst = 1'b0;
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    tohost_monitor_if ifa ();
    tohost_monitor_if ifw ();
    tohost_monitor_if ifz ();

    logic        done_a, pass_a, fail_a, tmo_a, halt_a;
    logic [30:0] ft_a;
    logic [31:0] cyc_a;
    logic        done_w, pass_w, fail_w, tmo_w, halt_w;
    logic [30:0] ft_w;
    logic [31:0] cyc_w;
    logic        done_z, pass_z, fail_z, tmo_z, halt_z;
    logic [30:0] ft_z;
    logic [31:0] cyc_z;

    tohost_monitor dut_a (
        .sys_clk(clk), .sys_res(rst), .bus(ifa),
        .done(done_a), .pass(pass_a), .fail(fail_a), .timeout(tmo_a),
        .fail_test(ft_a), .cycles(cyc_a), .halt(halt_a)
    );

    tohost_monitor #(.TIMEOUT_CYCLES(20)) dut_w (
        .sys_clk(clk), .sys_res(rst), .bus(ifw),
        .done(done_w), .pass(pass_w), .fail(fail_w), .timeout(tmo_w),
        .fail_test(ft_w), .cycles(cyc_w), .halt(halt_w)
    );

    tohost_monitor #(.TIMEOUT_CYCLES(0)) dut_z (
        .sys_clk(clk), .sys_res(rst), .bus(ifz),
        .done(done_z), .pass(pass_z), .fail(fail_z), .timeout(tmo_z),
        .fail_test(ft_z), .cycles(cyc_z), .halt(halt_z)
    );

    task automatic idle_all();
        ifa.mem_we = 1'b0; ifa.mem_addr = '0; ifa.mem_wdata = '0; ifa.mem_wmask = '0;
        ifw.mem_we = 1'b0; ifw.mem_addr = '0; ifw.mem_wdata = '0; ifw.mem_wmask = '0;
        ifz.mem_we = 1'b0; ifz.mem_addr = '0; ifz.mem_wdata = '0; ifz.mem_wmask = '0;
    endtask

    // Reset asserted and released on falling edges; the next rising edge
    // is the first counted edge (cycles becomes 1).
    task automatic do_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_all();
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic write_a(input logic [31:0] addr, input logic [31:0] data, input logic [3:0] mask);
        ifa.mem_we = 1'b1; ifa.mem_addr = addr; ifa.mem_wdata = data; ifa.mem_wmask = mask;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b1;
        idle_all();
        #2;
        checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL reset.done got=%0d exp=0", done_a); end
        checks++; if (pass_a !== 1'b0) begin failures++; $display("FAIL reset.pass got=%0d exp=0", pass_a); end
        checks++; if (fail_a !== 1'b0) begin failures++; $display("FAIL reset.fail got=%0d exp=0", fail_a); end
        checks++; if (tmo_a !== 1'b0) begin failures++; $display("FAIL reset.timeout got=%0d exp=0", tmo_a); end
        checks++; if (halt_a !== 1'b0) begin failures++; $display("FAIL reset.halt got=%0d exp=0", halt_a); end
        checks++; if (ft_a !== 31'd0) begin failures++; $display("FAIL reset.fail_test got=%0d exp=0", ft_a); end
        checks++; if (cyc_a !== 32'd0) begin failures++; $display("FAIL reset.cycles got=%0d exp=0", cyc_a); end
        @(negedge clk);
        rst = 1'b0;
    endtask

    task automatic test_pass();
        do_reset();
        repeat (10) @(posedge clk);
        @(negedge clk);
        write_a(32'h0000_1000, 32'h1, 4'hF);
        @(posedge clk);
        #1;
        ifa.mem_we = 1'b0;
        checks++; if (done_a !== 1'b1) begin failures++; $display("FAIL pass.done got=%0d exp=1", done_a); end
        checks++; if (pass_a !== 1'b1) begin failures++; $display("FAIL pass.pass got=%0d exp=1", pass_a); end
        checks++; if (halt_a !== 1'b1) begin failures++; $display("FAIL pass.halt got=%0d exp=1", halt_a); end
        checks++; if (fail_a !== 1'b0) begin failures++; $display("FAIL pass.fail got=%0d exp=0", fail_a); end
        checks++; if (tmo_a !== 1'b0) begin failures++; $display("FAIL pass.timeout got=%0d exp=0", tmo_a); end
        checks++; if (ft_a !== 31'd0) begin failures++; $display("FAIL pass.fail_test got=%0d exp=0", ft_a); end
        checks++; if (cyc_a !== 32'd11) begin failures++; $display("FAIL pass.cycles got=%0d exp=11", cyc_a); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (cyc_a !== 32'd11) begin failures++; $display("FAIL pass.cycles_held got=%0d exp=11", cyc_a); end
        checks++; if (pass_a !== 1'b1) begin failures++; $display("FAIL pass.pass_held got=%0d exp=1", pass_a); end
    endtask

    task automatic test_fail();
        do_reset();
        repeat (3) @(posedge clk);
        @(negedge clk);
        write_a(32'h0000_1000, 32'h0000_0007, 4'hF);
        @(posedge clk);
        #1;
        ifa.mem_we = 1'b0;
        checks++; if (fail_a !== 1'b1) begin failures++; $display("FAIL fail.fail got=%0d exp=1", fail_a); end
        checks++; if (ft_a !== 31'd3) begin failures++; $display("FAIL fail.fail_test got=%0d exp=3", ft_a); end
        checks++; if (pass_a !== 1'b0) begin failures++; $display("FAIL fail.pass got=%0d exp=0", pass_a); end
        checks++; if (done_a !== 1'b1) begin failures++; $display("FAIL fail.done got=%0d exp=1", done_a); end
        checks++; if (cyc_a !== 32'd4) begin failures++; $display("FAIL fail.cycles got=%0d exp=4", cyc_a); end
        @(negedge clk);
        write_a(32'h0000_1000, 32'h1, 4'hF);
        @(posedge clk);
        #1;
        ifa.mem_we = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++; if (pass_a !== 1'b0) begin failures++; $display("FAIL fail.late_pass got=%0d exp=0", pass_a); end
        checks++; if (fail_a !== 1'b1) begin failures++; $display("FAIL fail.late_fail got=%0d exp=1", fail_a); end
        checks++; if (ft_a !== 31'd3) begin failures++; $display("FAIL fail.late_fail_test got=%0d exp=3", ft_a); end
        checks++; if (cyc_a !== 32'd4) begin failures++; $display("FAIL fail.late_cycles got=%0d exp=4", cyc_a); end
    endtask

    task automatic test_ignored();
        do_reset();
        write_a(32'h0000_1000, 32'h0, 4'hF);          // zero to tohost: edge 0
        @(negedge clk);
        write_a(32'h0000_1000, 32'h1, 4'h1);          // partial mask: edge 1
        @(negedge clk);
        write_a(32'h0000_1004, 32'h1, 4'hF);          // other address: edge 2
        @(negedge clk);
        write_a(32'h0000_1000, 32'h2, 4'hF);          // even value: edge 3
        @(negedge clk);
        ifa.mem_we = 1'b0;
        checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL ignored.done got=%0d exp=0", done_a); end
        checks++; if (pass_a !== 1'b0) begin failures++; $display("FAIL ignored.pass got=%0d exp=0", pass_a); end
        checks++; if (fail_a !== 1'b0) begin failures++; $display("FAIL ignored.fail got=%0d exp=0", fail_a); end
        checks++; if (cyc_a !== 32'd4) begin failures++; $display("FAIL ignored.cycles got=%0d exp=4", cyc_a); end
        repeat (6) @(posedge clk);
        #1;
        checks++; if (cyc_a !== 32'd10) begin failures++; $display("FAIL ignored.cycles_run got=%0d exp=10", cyc_a); end
        checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL ignored.done_run got=%0d exp=0", done_a); end
    endtask

    task automatic test_watchdog();
        do_reset();
        repeat (19) @(posedge clk);
        #1;
        checks++; if (tmo_w !== 1'b0) begin failures++; $display("FAIL wdog.early_timeout got=%0d exp=0", tmo_w); end
        checks++; if (cyc_w !== 32'd19) begin failures++; $display("FAIL wdog.early_cycles got=%0d exp=19", cyc_w); end
        @(posedge clk);
        #1;
        checks++; if (tmo_w !== 1'b1) begin failures++; $display("FAIL wdog.timeout got=%0d exp=1", tmo_w); end
        checks++; if (done_w !== 1'b1) begin failures++; $display("FAIL wdog.done got=%0d exp=1", done_w); end
        checks++; if (halt_w !== 1'b1) begin failures++; $display("FAIL wdog.halt got=%0d exp=1", halt_w); end
        checks++; if (pass_w !== 1'b0) begin failures++; $display("FAIL wdog.pass got=%0d exp=0", pass_w); end
        checks++; if (fail_w !== 1'b0) begin failures++; $display("FAIL wdog.fail got=%0d exp=0", fail_w); end
        checks++; if (cyc_w !== 32'd20) begin failures++; $display("FAIL wdog.cycles got=%0d exp=20", cyc_w); end
        repeat (5) @(posedge clk);
        #1;
        checks++; if (cyc_w !== 32'd20) begin failures++; $display("FAIL wdog.cycles_held got=%0d exp=20", cyc_w); end
    endtask

    task automatic test_watchdog_commit();
        do_reset();
        repeat (19) @(posedge clk);
        @(negedge clk);
        ifw.mem_we = 1'b1; ifw.mem_addr = 32'h0000_1000; ifw.mem_wdata = 32'h1; ifw.mem_wmask = 4'hF;
        @(posedge clk);
        #1;
        ifw.mem_we = 1'b0;
        checks++; if (pass_w !== 1'b1) begin failures++; $display("FAIL wdog_commit.pass got=%0d exp=1", pass_w); end
        checks++; if (tmo_w !== 1'b0) begin failures++; $display("FAIL wdog_commit.timeout got=%0d exp=0", tmo_w); end
        checks++; if (cyc_w !== 32'd20) begin failures++; $display("FAIL wdog_commit.cycles got=%0d exp=20", cyc_w); end
    endtask

    task automatic test_reset_midrun();
        do_reset();
        repeat (7) @(posedge clk);
        #2;
        checks++; if (cyc_a !== 32'd7) begin failures++; $display("FAIL rst_mid.pre_cycles got=%0d exp=7", cyc_a); end
        rst = 1'b1;
        #1;
        checks++; if (cyc_a !== 32'd0) begin failures++; $display("FAIL rst_mid.cycles got=%0d exp=0", cyc_a); end
        checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL rst_mid.done got=%0d exp=0", done_a); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (cyc_a !== 32'd1) begin failures++; $display("FAIL rst_mid.restart got=%0d exp=1", cyc_a); end
        @(negedge clk);
        write_a(32'h0000_1000, 32'h1, 4'hF);
        @(posedge clk);
        #1;
        ifa.mem_we = 1'b0;
        checks++; if (pass_a !== 1'b1) begin failures++; $display("FAIL rst_post.pre_pass got=%0d exp=1", pass_a); end
        #1;
        rst = 1'b1;
        #1;
        checks++; if (pass_a !== 1'b0) begin failures++; $display("FAIL rst_post.pass got=%0d exp=0", pass_a); end
        checks++; if (done_a !== 1'b0) begin failures++; $display("FAIL rst_post.done got=%0d exp=0", done_a); end
        checks++; if (halt_a !== 1'b0) begin failures++; $display("FAIL rst_post.halt got=%0d exp=0", halt_a); end
        checks++; if (cyc_a !== 32'd0) begin failures++; $display("FAIL rst_post.cycles got=%0d exp=0", cyc_a); end
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (cyc_a !== 32'd1) begin failures++; $display("FAIL rst_post.restart got=%0d exp=1", cyc_a); end
    endtask

    task automatic test_no_watchdog();
        do_reset();
        repeat (1000) @(posedge clk);
        #1;
        checks++; if (done_z !== 1'b0) begin failures++; $display("FAIL nowdog.done got=%0d exp=0", done_z); end
        checks++; if (tmo_z !== 1'b0) begin failures++; $display("FAIL nowdog.timeout got=%0d exp=0", tmo_z); end
        checks++; if (cyc_z !== 32'd1000) begin failures++; $display("FAIL nowdog.cycles got=%0d exp=1000", cyc_z); end
    endtask

    initial begin
        idle_all();
        test_reset();
        test_pass();
        test_fail();
        test_ignored();
        test_watchdog();
        test_watchdog_commit();
        test_reset_midrun();
        test_no_watchdog();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
